// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for the byte-addressable data memory.
// Port A (CPU load/store unit) and port B (DMA/debug loader) compete for one memory access at a
// time. A granted request spends exactly one cycle driving the memory (ACCESS) and then holds a
// registered response until the owner consumes it (RESP).
// Optional build macro: DMEM_ARB_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.

module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Port A: CPU load/store unit
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic                  a_req_we,
    input  logic [2:0]            a_req_size,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
    output logic                  a_rsp_err,

    // Port B: secondary master
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic                  b_req_we,
    input  logic [2:0]            b_req_size,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
    output logic                  b_rsp_err,

    // Data memory
    output logic                  mem_we,
    output logic [2:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Size codes understood by the memory
    localparam logic [2:0] SzB  = 3'b000;
    localparam logic [2:0] SzH  = 3'b001;
    localparam logic [2:0] SzW  = 3'b010;
    localparam logic [2:0] SzBu = 3'b100;
    localparam logic [2:0] SzHu = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e                state_q;
    logic                  last_grant_q;  // 0 = A, 1 = B
    logic                  owner_q;       // 0 = A, 1 = B
    logic                  req_we_q;
    logic                  illegal_q;

    // The memory-facing registers double as the request latch
    logic                  mem_we_q;
    logic [2:0]            mem_size_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic                  a_rsp_valid_q;
    logic                  a_rsp_err_q;
    logic [DATA_WIDTH-1:0] a_rsp_rdata_q;
    logic                  b_rsp_valid_q;
    logic                  b_rsp_err_q;
    logic [DATA_WIDTH-1:0] b_rsp_rdata_q;

    logic                  grant_a;
    logic                  grant_b;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [2:0]            sel_size;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_illegal;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  owner_rsp_ready;

    // Round-robin winner selection; only meaningful while idle
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == StIdle) begin
            if (a_req_valid && (!b_req_valid || last_grant_q)) begin
                grant_a = 1'b1;
            end else if (b_req_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    // Request fields of the winner (A when nobody wins; unused then)
    always_comb begin
        if (grant_b) begin
            sel_addr  = b_req_addr;
            sel_we    = b_req_we;
            sel_size  = b_req_size;
            sel_wdata = b_req_wdata;
        end else begin
            sel_addr  = a_req_addr;
            sel_we    = a_req_we;
            sel_size  = a_req_size;
            sel_wdata = a_req_wdata;
        end
    end

    // Legality of the winning request: unknown size codes and unsigned-size stores are rejected
    always_comb begin
        sel_illegal = 1'b0;
        case (sel_size)
            SzB, SzH, SzW: sel_illegal = 1'b0;
            SzBu, SzHu:    sel_illegal = sel_we;
            default:       sel_illegal = 1'b1;
        endcase
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        if ((sel_size == SzH || sel_size == SzHu) && sel_addr[0]) begin
            sel_illegal = 1'b1;
        end
        if (sel_size == SzW && sel_addr[1:0] != 2'b00) begin
            sel_illegal = 1'b1;
        end
`endif
    end

    // Response data: only a legal load returns memory data
    always_comb begin
        load_data = '0;
        if (!req_we_q && !illegal_q) begin
            load_data = mem_rdata;
        end
    end

    // Response ready of whichever port owns the current transaction
    always_comb begin
        owner_rsp_ready = owner_q ? b_rsp_ready : a_rsp_ready;
    end

    // Sequencer FSM with registered memory and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            req_we_q      <= 1'b0;
            illegal_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_size_q    <= 3'b000;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            a_rsp_valid_q <= 1'b0;
            a_rsp_err_q   <= 1'b0;
            a_rsp_rdata_q <= '0;
            b_rsp_valid_q <= 1'b0;
            b_rsp_err_q   <= 1'b0;
            b_rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_a || grant_b) begin
                        owner_q      <= grant_b;
                        last_grant_q <= grant_b;
                        req_we_q     <= sel_we;
                        illegal_q    <= sel_illegal;
                        mem_addr_q   <= sel_addr;
                        mem_size_q   <= sel_size;
                        mem_wdata_q  <= sel_wdata;
                        // Write strobe is live for the single ACCESS cycle that follows
                        mem_we_q     <= sel_we && !sel_illegal;
                        state_q      <= StAccess;
                    end
                end
                StAccess: begin
                    mem_we_q <= 1'b0;
                    if (owner_q) begin
                        b_rsp_valid_q <= 1'b1;
                        b_rsp_err_q   <= illegal_q;
                        b_rsp_rdata_q <= load_data;
                    end else begin
                        a_rsp_valid_q <= 1'b1;
                        a_rsp_err_q   <= illegal_q;
                        a_rsp_rdata_q <= load_data;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    if (owner_rsp_ready) begin
                        a_rsp_valid_q <= 1'b0;
                        b_rsp_valid_q <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_size    = mem_size_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

    assign a_rsp_valid = a_rsp_valid_q;
    assign a_rsp_err   = a_rsp_err_q;
    assign a_rsp_rdata = a_rsp_rdata_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign b_rsp_err   = b_rsp_err_q;
    assign b_rsp_rdata = b_rsp_rdata_q;

endmodule
